bus_b2a_reader: RTL and testbench

BUS_B2A_READER -- requirements
Module: bus_b2a_reader

---
 rtl/bus_b2a_reader.sv | 98 +++++++++
 tb/tb_bus_b2a_reader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bus_b2a_reader.sv
// Captures B-side bus words into a small FWFT buffer that the A side drains.
// Optional per-entry odd-parity check when BUS_B2A_PARITY_EN is defined.
module bus_b2a_reader #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] b_data,
  input  logic       b_en_n,
  input  logic       b_dir,
  input  logic       b_strobe,
  input  logic       b_par,
  output logic [7:0] a_data,
  output logic       a_perr,
  output logic       a_valid,
  input  logic       a_ready,
  output logic [4:0] count,
  output logic       full,
  output logic       overrun,
  input  logic       clr_ovr
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          cap, pop, push;

  assign cap     = b_strobe & ~b_en_n & ~b_dir;
  assign a_valid = (count_q != 5'd0);
  assign full    = (count_q == 5'(DEPTH));
  assign pop     = a_valid & a_ready;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push    = cap & (~full | pop);

  assign count   = count_q;
  assign overrun = overrun_q;
  assign a_data  = a_valid ? mem_q[rd_ptr_q] : 8'h00;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = b_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d   = count_q + {4'd0, push} - {4'd0, pop};
    overrun_d = (cap & full & ~pop) | (overrun_q & ~clr_ovr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef BUS_B2A_PARITY_EN
  logic perr_q [DEPTH];
  logic perr_d [DEPTH];

  // Odd parity over data+parity bit: an even number of ones is an error.
  always_comb begin
    perr_d = perr_q;
    if (push) perr_d[wr_ptr_q] = ~^{b_data, b_par};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) perr_q[i] <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign a_perr = a_valid & perr_q[rd_ptr_q];
`else
  logic unused_b_par;
  assign unused_b_par = b_par;
  assign a_perr       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_b2a_reader.sv
// Scoreboard bench for bus_b2a_reader: a queue model of the buffer is updated
// as stimulus is driven and compared against the DUT every cycle.
module tb_bus_b2a_reader;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_en_n = 1'b1, b_dir = 1'b0, b_strobe = 1'b0, b_par = 1'b0;
  logic [7:0] a_data;
  logic       a_perr, a_valid, full, overrun;
  logic       a_ready = 1'b0, clr_ovr = 1'b0;
  logic [4:0] count;

  bus_b2a_reader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .b_data(b_data), .b_en_n(b_en_n), .b_dir(b_dir),
    .b_strobe(b_strobe), .b_par(b_par), .a_data(a_data), .a_perr(a_perr),
    .a_valid(a_valid), .a_ready(a_ready), .count(count), .full(full),
    .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  int        nchk = 0, nfail = 0;
  bit [8:0]  sb[$];   // {perr, data} per buffered entry
  bit        m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("count",   32'(count),   32'(sb.size()));
    chk("full",    32'(full),    32'(sb.size() == DEPTH));
    chk("a_valid", 32'(a_valid), 32'(sb.size() != 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("a_data",  32'(a_data),  sb.size() != 0 ? 32'(sb[0][7:0]) : 32'h0);
    chk("a_perr",  32'(a_perr),  sb.size() != 0 ? 32'(sb[0][8])   : 32'h0);
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic step(input bit s, input bit [7:0] d, input bit p, input bit en_n,
                      input bit dir, input bit rdy, input bit clr);
    bit mcap, mpop, mpush;
    bit [8:0] ent;
    b_strobe = s; b_data = d; b_par = p; b_en_n = en_n; b_dir = dir;
    a_ready = rdy; clr_ovr = clr;
    mcap = s & ~en_n & ~dir;
    mpop = rdy && (sb.size() != 0);
`ifdef BUS_B2A_PARITY_EN
    ent = {~^{d, p}, d};
`else
    ent = {1'b0, d};
`endif
    if (mpop) chk("pop_data", 32'(a_data), 32'(sb[0][7:0]));
    mpush = mcap && (sb.size() < DEPTH || mpop);
    m_ovr = (mcap && sb.size() == DEPTH && !mpop) || (m_ovr && !clr);
    if (mpop) void'(sb.pop_front());
    if (mpush) sb.push_back(ent);
    @(posedge clk); #1;
    b_strobe = 1'b0; a_ready = 1'b0; clr_ovr = 1'b0; b_en_n = 1'b1; b_dir = 1'b0;
    chk_state();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_count"},   32'(count),   0);
    chk({tag, "_valid"},   32'(a_valid), 0);
    chk({tag, "_data"},    32'(a_data),  0);
    chk({tag, "_perr"},    32'(a_perr),  0);
    chk({tag, "_full"},    32'(full),    0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // First capture appears one cycle later.
    step(1, 8'hA5, 0, 0, 0, 0, 0);
    chk("first_data", 32'(a_data), 32'hA5);
    step(0, 8'h00, 0, 0, 0, 1, 0);

    // Fill, overflow with 0x05, then drain 0x01..0x04.
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0, 0, 0, 0);
    step(1, 8'h05, 0, 0, 0, 0, 0);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overrun), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", 32'(a_data), 32'(i));
      step(0, 8'h00, 0, 0, 0, 1, 0);
    end

    // Overrun is sticky until cleared.
    step(0, 8'h00, 0, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    chk("ovr_cleared", 32'(overrun), 0);

    // Full plus simultaneous cap and pop keeps count at DEPTH; 0x77 comes last.
    for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 0, 0, 0, 0, 0);
    step(1, 8'h77, 0, 0, 0, 1, 0);
    chk("cap_pop_count", 32'(count), 4);
    chk("cap_pop_ovr", 32'(overrun), 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 0, 1, 0);

    // Set wins over clear in the same cycle.
    for (int i = 0; i < 4; i++) step(1, 8'h20 + 8'(i), 0, 0, 0, 0, 0);
    step(1, 8'h99, 0, 0, 0, 0, 1);
    chk("set_wins", 32'(overrun), 1);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 0, 1, 0);

    // Strobes with the bus turned away or disabled are ignored.
    step(1, 8'h33, 0, 0, 1, 0, 0);
    step(1, 8'h44, 0, 1, 0, 0, 0);
    step(1, 8'h55, 0, 1, 1, 0, 0);
    chk("inhibit_count", 32'(count), 0);
    chk("inhibit_ovr", 32'(overrun), 0);

`ifdef BUS_B2A_PARITY_EN
    step(1, 8'h03, 0, 0, 0, 0, 0);
    chk("par_even", 32'(a_perr), 1);
    step(1, 8'h03, 1, 0, 0, 1, 0);
    chk("par_odd", 32'(a_perr), 0);
    step(0, 8'h00, 0, 0, 0, 1, 0);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);

    // Asynchronous reset mid-burst: outputs clear without a clock edge.
    for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    sb.delete();
    m_ovr = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state();
    step(1, 8'h5A, 0, 0, 0, 0, 0);
    chk("post_rst_data", 32'(a_data), 32'h5A);
    step(0, 8'h00, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
